// File: rtl/delay_pkg.sv
// Shared types for the delay stimulus/response stage: FSM states and the
// buffered vector entry.
package delay_pkg;

    localparam int DEF_HOLD_W = 8;
    // Entries carry a hold field wide enough for any supported HOLD_W.
    localparam int HOLD_W_MAX = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        REPORT = 2'd2
    } state_e;

    typedef struct packed {
        logic                  a;
        logic                  b;
        logic [HOLD_W_MAX-1:0] hold;
    } entry_t;

endpackage

// File: rtl/delay_stim_fifo.sv
// Synchronous FIFO for stimulus vectors. Pointers are one bit wider than the
// index so full and empty are distinguishable without a counter.
module delay_stim_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, rptr_q;
    logic         wr_en, rd_en;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign wr_en   = push_i && !full_o;
    assign rd_en   = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (rd_en) rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/delay_stim_driver.sv
// Applies buffered a/b vectors to the block under study, holds them for a
// programmed window and reports the final c plus the first-change latency.
module delay_stim_driver
    import delay_pkg::*;
#(
    parameter int HOLD_W = DEF_HOLD_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_a,
    input  logic              in_b,
    input  logic [HOLD_W-1:0] in_hold,
    output logic              dut_a,
    output logic              dut_b,
    input  logic              dut_c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_c,
    output logic [HOLD_W-1:0] out_lat,
    output logic              out_seen,
    output logic              busy
);

    state_e            state_q, state_d;
    entry_t            push_ent, head;
    logic              fifo_full, fifo_empty;
    logic              push, pop;
    logic              dut_a_q, dut_b_q, c_ref_q, seen_q, out_c_q;
    logic [HOLD_W-1:0] k_q, hold_q, lat_q, hold_eff;

    assign in_ready = rst_n && !fifo_full;
    assign push     = in_valid && in_ready;
    assign push_ent = '{a: in_a, b: in_b, hold: HOLD_W_MAX'(in_hold)};

    delay_stim_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_ent),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A zero hold still needs one sample to produce a result.
    assign hold_eff = (head.hold == '0) ? HOLD_W'(1) : head.hold[HOLD_W-1:0];

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (k_q == hold_q) state_d = REPORT;
            end
            REPORT: begin
                if (out_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dut_a_q <= 1'b0;
            dut_b_q <= 1'b0;
            c_ref_q <= 1'b0;
            seen_q  <= 1'b0;
            out_c_q <= 1'b0;
            lat_q   <= '0;
            k_q     <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                dut_a_q <= head.a;
                dut_b_q <= head.b;
                c_ref_q <= dut_c;
                seen_q  <= 1'b0;
                lat_q   <= '0;
                k_q     <= HOLD_W'(1);
                hold_q  <= hold_eff;
            end else if (state_q == SETTLE) begin
                if ((dut_c != c_ref_q) && !seen_q) begin
                    lat_q  <= k_q;
                    seen_q <= 1'b1;
                end
                if (k_q == hold_q) out_c_q <= dut_c;
                else               k_q     <= k_q + 1'b1;
            end
        end
    end

    assign dut_a     = dut_a_q;
    assign dut_b     = dut_b_q;
    assign out_valid = (state_q == REPORT);
    assign out_c     = out_c_q;
    assign out_lat   = lat_q;
    assign out_seen  = seen_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_delay_stim_driver.sv
// Directed bench: c = a ^ b through a configurable register delay, measured
// from the apply edge so a delay of N shows up as latency N (N>=1).
module tb_delay_stim_driver;

    logic       clk, rst_n;
    logic       in_valid, in_ready, in_a, in_b;
    logic [7:0] in_hold;
    logic       dut_a, dut_b, dut_c;
    logic       out_valid, out_ready, out_c, out_seen, busy;
    logic [7:0] out_lat;

    int         n_dly = 0;
    logic [7:0] sh = '0;
    int         n_pass = 0, n_total = 0;

    delay_stim_driver #(.HOLD_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_hold(in_hold),
        .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_lat(out_lat), .out_seen(out_seen),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dut_a/dut_b are already one register past the apply edge.
    always @(posedge clk) sh <= {sh[6:0], dut_a ^ dut_b};
    assign dut_c = (n_dly <= 1) ? (dut_a ^ dut_b) : sh[n_dly-2];

    typedef struct {
        int n;
        bit a, b;
        int hold;
        int e_edges;
        bit e_c;
        int e_lat;
        bit e_seen;
    } vec_t;

    typedef struct {
        bit a, b;
        bit e_c;
        int e_lat;
        bit e_seen;
    } bp_t;

    vec_t tbl[8];
    bp_t  bp[5];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int got;
        n_dly = v.n;
        repeat (6) @(negedge clk);
        in_a = v.a; in_b = v.b; in_hold = 8'(v.hold); in_valid = 1'b1;
        @(posedge clk);
        got = -1;
        for (int m = 1; m <= 400; m++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                got = m;
                break;
            end
        end
        chk($sformatf("v%0d_edges", idx), got, v.e_edges);
        chk($sformatf("v%0d_out_c", idx), out_c, v.e_c);
        chk($sformatf("v%0d_out_lat", idx), out_lat, v.e_lat);
        chk($sformatf("v%0d_out_seen", idx), out_seen, v.e_seen);
        chk($sformatf("v%0d_dut_a", idx), dut_a, v.a);
        chk($sformatf("v%0d_dut_b", idx), dut_b, v.b);
        @(negedge clk);
        chk($sformatf("v%0d_valid_drop", idx), out_valid, 0);
        chk($sformatf("v%0d_busy_drop", idx), busy, 0);
    endtask

    initial begin
        int idx, lowrun, any_valid;

        //        n  a  b  hold edges c lat seen
        tbl[0] = '{3, 1, 0, 2,   4,   0, 0, 0};  // window too short
        tbl[1] = '{3, 0, 0, 5,   7,   0, 3, 1};
        tbl[2] = '{3, 1, 0, 5,   7,   1, 3, 1};
        tbl[3] = '{3, 1, 1, 4,   6,   0, 3, 1};
        tbl[4] = '{0, 0, 1, 0,   3,   1, 1, 1};  // zero hold, toggles
        tbl[5] = '{0, 1, 0, 0,   3,   1, 0, 0};  // zero hold, no change
        tbl[6] = '{3, 0, 0, 3,   5,   0, 3, 1};  // change on last sample
        tbl[7] = '{0, 1, 0, 255, 257, 1, 1, 1};  // maximum hold

        bp[0] = '{1, 0, 1, 1, 1};
        bp[1] = '{0, 1, 1, 0, 0};
        bp[2] = '{1, 1, 0, 1, 1};
        bp[3] = '{0, 0, 0, 0, 0};
        bp[4] = '{1, 0, 1, 1, 1};

        // Reset held with a vector offered throughout.
        rst_n = 1'b0; in_valid = 1'b1; in_a = 1'b1; in_b = 1'b0; in_hold = 8'd3;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_dut_a", dut_a, 0);
            chk("rst_dut_b", dut_b, 0);
            chk("rst_out_c", out_c, 0);
            chk("rst_out_lat", out_lat, 0);
            chk("rst_out_seen", out_seen, 0);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);
        repeat (10) @(negedge clk);

        foreach (tbl[i]) run_vec(tbl[i], i);

        // Backpressure: result stalled, buffer fills behind it.
        n_dly = 0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_ready%0d", i), in_ready, 1);
            in_a = bp[i].a; in_b = bp[i].b; in_hold = 8'd2; in_valid = 1'b1;
        end
        @(negedge clk);
        in_a = 1'b0; in_b = 1'b1;
        chk("bp_full_ready", in_ready, 0);
        chk("bp_full_busy", busy, 1);
        chk("bp_stalled_valid", out_valid, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_still_full", in_ready, 0);
        out_ready = 1'b1;
        idx = 0; lowrun = 0;
        for (int c = 0; c < 200 && idx < 5; c++) begin
            if (out_valid) begin
                chk($sformatf("bp%0d_out_c", idx), out_c, bp[idx].e_c);
                chk($sformatf("bp%0d_out_lat", idx), out_lat, bp[idx].e_lat);
                chk($sformatf("bp%0d_out_seen", idx), out_seen, bp[idx].e_seen);
                if (idx > 0) chk($sformatf("bp%0d_gap", idx), lowrun, 2);
                idx++;
                lowrun = 0;
            end else begin
                lowrun++;
            end
            @(negedge clk);
        end
        chk("bp_result_count", idx, 5);
        chk("bp_busy_after", busy, 0);
        chk("bp_valid_after", out_valid, 0);

        // Reset pulse mid-SETTLE with two vectors still queued.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            in_a = 1'b1; in_b = 1'b1; in_hold = 8'd10; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("mr_applied_a", dut_a, 1);
        chk("mr_busy_before", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_out_valid", out_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_dut_a", dut_a, 0);
        chk("mr_dut_b", dut_b, 0);
        rst_n = 1'b1;
        any_valid = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) any_valid = 1;
        end
        chk("mr_no_result", any_valid, 0);
        chk("mr_busy_idle", busy, 0);
        chk("mr_in_ready", in_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
